// File: rtl/keyed_seq_lock_pkg.sv
// ============================================================================
// Module      : keyed_seq_lock_pkg
// Description : Shared state encoding and LFSR constants for keyed_seq_lock.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package keyed_seq_lock_pkg;

  typedef enum logic [1:0] {
    ST_OBF   = 2'd0,
    ST_DECOY = 2'd1,
    ST_FUNC  = 2'd2,
    ST_BRICK = 2'd3
  } lock_state_e;

  localparam int          LFSR_W            = 16;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form (bits 0,2,3,5)
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/lock_lfsr16.sv
// ============================================================================
// Module      : lock_lfsr16
// Description : 16-bit Fibonacci LFSR with enable, used to scramble obfuscated data.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lock_lfsr16
  import keyed_seq_lock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic              w_feedback;

  assign w_feedback = ^(state_q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= seed;
    end else if (en) begin
      state_q <= {w_feedback, state_q[LFSR_W-1:1]};
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: rtl/keyed_seq_lock.sv
// ============================================================================
// Module      : keyed_seq_lock
// Description : Key-sequence unlock FSM gating a one-stage data path.
//               Macro DECOY_SCRAMBLE_EN enables LFSR scrambling in OBF/DECOY.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keyed_seq_lock
  import keyed_seq_lock_pkg::*;
#(
  parameter int                    DATA_W     = 8,
  parameter int                    KEY_W      = 8,
  parameter int                    KEY_LEN    = 4,
  parameter logic [KEY_LEN*KEY_W-1:0] KEY_SEQ = {8'hD4, 8'hC3, 8'hB2, 8'hA1},
  parameter int                    FAIL_LIMIT = 3,
  parameter int                    DECOY_CYC  = 4,
  parameter logic [15:0]           LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_vld,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              unlocked,
  output logic              bricked
);

  localparam int IDX_W  = $clog2(KEY_LEN + 1);
  localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);
  localparam int DEC_W  = $clog2(DECOY_CYC + 1);

  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(KEY_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_ONE  = FAIL_W'(1);
  localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(FAIL_LIMIT);
  localparam logic [DEC_W-1:0]  DEC_ONE   = DEC_W'(1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECOY_CYC - 1);

  if (LFSR_SEED == 16'h0000) begin : g_seed_check
    $error("keyed_seq_lock: LFSR_SEED must be nonzero");
  end

  lock_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [DEC_W-1:0]  decoy_q, decoy_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;

  logic [KEY_W-1:0]  w_key_word;
  logic [DATA_W-1:0] w_obf_data;
  logic              w_scramble_adv;

  assign w_key_word     = KEY_SEQ[idx_q*KEY_W +: KEY_W];
  assign w_scramble_adv = (state_q == ST_OBF) || (state_q == ST_DECOY);

`ifdef DECOY_SCRAMBLE_EN
  logic [LFSR_W-1:0] w_lfsr;

  lock_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_scramble_adv),
    .seed  (LFSR_SEED),
    .state (w_lfsr)
  );

  assign w_obf_data = din ^ w_lfsr[DATA_W-1:0];
`else
  assign w_obf_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OBF;
      idx_q      <= '0;
      fail_q     <= '0;
      decoy_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      decoy_q    <= decoy_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    decoy_d = decoy_q;
    case (state_q)
      ST_OBF: begin
        if (key_vld) begin
          if (key_in == w_key_word) begin
            idx_d = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) state_d = ST_FUNC;
          end else begin
            idx_d  = '0;
            fail_d = fail_q + FAIL_ONE;
            if (fail_d == FAIL_MAX) begin
              state_d = ST_BRICK;
            end else begin
              state_d = ST_DECOY;
              decoy_d = '0;
            end
          end
        end
      end
      ST_DECOY: begin
        // decoy_q counts completed DECOY cycles; the last one hands back to OBF
        if (decoy_q == DEC_LAST) begin
          state_d = ST_OBF;
          idx_d   = '0;
          decoy_d = '0;
        end else begin
          decoy_d = decoy_q + DEC_ONE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    unlocked   = (state_q == ST_FUNC);
    bricked    = (state_q == ST_BRICK);
    dout_d     = w_obf_data;
    dout_vld_d = din_vld;
    case (state_q)
      ST_FUNC:  dout_d = din;
      ST_BRICK: begin
        dout_d     = '0;
        dout_vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_keyed_seq_lock.sv
// ============================================================================
// Module      : tb_keyed_seq_lock
// Description : Self-checking bench for keyed_seq_lock against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_keyed_seq_lock;

  logic       clk;
  logic       rst;
  logic [7:0] key_in;
  logic       key_vld;
  logic [7:0] din;
  logic       din_vld;
  logic [7:0] dout;
  logic       dout_vld;
  logic       unlocked;
  logic       bricked;

  int checks = 0;
  int errors = 0;

`ifdef DECOY_SCRAMBLE_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  keyed_seq_lock dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_vld  (key_vld),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .unlocked (unlocked),
    .bricked  (bricked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference model
  localparam int M_OBF = 0, M_DECOY = 1, M_FUNC = 2, M_BRICK = 3;
  logic [7:0]  keys [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  int          m_mode;
  int          m_pos;
  int          m_wrong;
  int          m_decoy_left;
  logic [15:0] m_lfsr;
  logic [7:0]  m_dout;
  logic        m_vld;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  task automatic model_edge(input bit r, input bit kv, input logic [7:0] k,
                            input bit dv, input logic [7:0] d);
    if (r) begin
      m_mode = M_OBF; m_pos = 0; m_wrong = 0; m_decoy_left = 0;
      m_lfsr = 16'hACE1; m_dout = 8'h00; m_vld = 1'b0;
      return;
    end
    if (m_mode == M_FUNC)       begin m_dout = d; m_vld = dv; end
    else if (m_mode == M_BRICK) begin m_dout = 8'h00; m_vld = 1'b0; end
    else begin
      m_dout = SCR ? (d ^ m_lfsr[7:0]) : 8'h00;
      m_vld  = dv;
      m_lfsr = lfsr_next(m_lfsr);
    end
    if (m_mode == M_OBF && kv) begin
      if (k == keys[m_pos]) begin
        m_pos++;
        if (m_pos == 4) m_mode = M_FUNC;
      end else begin
        m_pos = 0;
        m_wrong++;
        if (m_wrong == 3) m_mode = M_BRICK;
        else begin m_mode = M_DECOY; m_decoy_left = 4; end
      end
    end else if (m_mode == M_DECOY) begin
      m_decoy_left--;
      if (m_decoy_left == 0) begin m_mode = M_OBF; m_pos = 0; end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit kv, input logic [7:0] k,
                       input bit dv, input logic [7:0] d);
    @(negedge clk);
    rst = r; key_vld = kv; key_in = k; din_vld = dv; din = d;
    @(posedge clk);
    model_edge(r, kv, k, dv, d);
    #1;
    check("unlocked", 16'(unlocked), 16'(m_mode == M_FUNC));
    check("bricked",  16'(bricked),  16'(m_mode == M_BRICK));
    check("dout",     16'(dout),     16'(m_dout));
    check("dout_vld", 16'(dout_vld), 16'(m_vld));
  endtask

  task automatic key(input logic [7:0] k);
    apply(0, 1, k, 0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 8'h00, 0, 8'h00);
  endtask

  task automatic full_seq();
    for (int i = 0; i < 4; i++) key(keys[i]);
  endtask

  typedef struct packed {
    bit r; bit kv; logic [7:0] k; bit dv; logic [7:0] d;
    bit e_unl; bit e_brk; bit chk_d; logic [7:0] e_dout; bit e_vld;
  } vec_t;

  vec_t tbl [8];

  initial begin
    rst = 1'b1; key_vld = 1'b0; key_in = '0; din_vld = 1'b0; din = '0;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'hB2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'hD4, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'hFF, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0};

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].r, tbl[i].kv, tbl[i].k, tbl[i].dv, tbl[i].d);
      check($sformatf("tbl%0d_unlocked", i), 16'(unlocked), 16'(tbl[i].e_unl));
      check($sformatf("tbl%0d_bricked", i),  16'(bricked),  16'(tbl[i].e_brk));
      check($sformatf("tbl%0d_vld", i),      16'(dout_vld), 16'(tbl[i].e_vld));
      if (tbl[i].chk_d) check($sformatf("tbl%0d_dout", i), 16'(dout), 16'(tbl[i].e_dout));
    end

    // Scramble: first OBF output with din=0 is the LFSR low byte
    apply(1, 0, 8'h00, 0, 8'h00);
    apply(0, 0, 8'h00, 1, 8'h00);
    check("scramble_dout", 16'(dout), SCR ? 16'h00E1 : 16'h0000);
    check("scramble_vld",  16'(dout_vld), 16'h0001);

    // Gapped keys
    apply(1, 0, 8'h00, 0, 8'h00);
    key(8'hA1); idle(3); key(8'hB2); key(8'hC3); idle(1); key(8'hD4);
    check("gapped_unlocked", 16'(unlocked), 16'h0001);

    // Wrong word, decoy ignores keys, then a full sequence unlocks
    apply(1, 0, 8'h00, 0, 8'h00);
    key(8'hA1); key(8'hFF);
    full_seq();
    check("decoy_ignores_keys", 16'(unlocked), 16'h0000);
    full_seq();
    check("post_decoy_unlock", 16'(unlocked), 16'h0001);

    // Brick after three failures
    apply(1, 0, 8'h00, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      key(8'hFF);
      if (i < 2) idle(4);
    end
    check("brick_flag", 16'(bricked), 16'h0001);
    apply(0, 0, 8'h00, 1, 8'hAA);
    check("brick_vld", 16'(dout_vld), 16'h0000);
    check("brick_dout", 16'(dout), 16'h0000);
    full_seq();
    check("brick_no_unlock", 16'(unlocked), 16'h0000);
    apply(1, 0, 8'h00, 0, 8'h00);
    check("brick_cleared", 16'(bricked), 16'h0000);

    // Reset mid-sequence: C3 afterwards is a wrong word
    key(8'hA1); key(8'hB2);
    apply(1, 0, 8'h00, 0, 8'h00);
    key(8'hC3); key(8'hD4);
    check("reset_mid_no_unlock", 16'(unlocked), 16'h0000);
    idle(3);
    full_seq();
    check("reset_mid_then_unlock", 16'(unlocked), 16'h0001);

    // Randomized run against the model
    apply(1, 0, 8'h00, 0, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      bit         r, kv, dv;
      logic [7:0] k, d;
      r  = ($urandom_range(0, 59) == 0);
      kv = $urandom_range(0, 1);
      k  = ($urandom_range(0, 9) < 8 && m_pos < 4) ? keys[m_pos] : 8'($urandom);
      dv = $urandom_range(0, 1);
      d  = 8'($urandom);
      apply(r, kv, k, dv, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keyed_seq_lock.md
# keyed_seq_lock

Parametrised key-sequence locked controller for the obfuscation benchmark set: a data path that stays scrambled until a secret sequence of key words is presented in order, with a decoy state on a wrong word and permanent lock-out after repeated failures. It generalises the single-bit keyed branch into a multi-word, multi-attempt unlock FSM. It is instantiated in front of a benchmark FSM's data inputs or outputs.

## Interface
- DATA_W, 8, data width, 1..16
- KEY_W, 8, key word width, 1..32
- KEY_LEN, 4, number of key words in the sequence, >=1
- KEY_SEQ, {8'hD4,8'hC3,8'hB2,8'hA1}, packed KEY_LEN*KEY_W; word i = KEY_SEQ[i*KEY_W +: KEY_W]; word 0 is presented first
- FAIL_LIMIT, 3, wrong-word count that bricks the block, >=1
- DECOY_CYC, 4, cycles spent in DECOY per failure, >=1
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- key_in  in  KEY_W  key word
- key_vld  in  1  key_in valid this cycle
- din  in  DATA_W  data in
- din_vld  in  1  din valid
- dout  out  DATA_W  registered data out
- dout_vld  out  1  registered valid
- unlocked  out  1  state == FUNC
- bricked  out  1  state == BRICK

## Operation
- States: OBF (with word index idx), DECOY, FUNC, BRICK.
- Reset: state=OBF, idx=0, fail_cnt=0, decoy_cnt=0, lfsr=LFSR_SEED, dout=0, dout_vld=0, unlocked=0, bricked=0.
- OBF, key_vld=0: hold idx.
- OBF, key_vld=1 and key_in == word idx: idx+1; if idx == KEY_LEN-1, go to FUNC.
- OBF, key_vld=1 and mismatch: idx=0, fail_cnt+1. If the new fail_cnt == FAIL_LIMIT, go to BRICK. Otherwise go to DECOY with decoy_cnt=0.
- DECOY: key_vld ignored. decoy_cnt increments each cycle. After DECOY_CYC cycles in DECOY, return to OBF with idx=0.
- FUNC: terminal until rst; key_vld ignored.
- BRICK: terminal until rst; key_vld ignored.
- fail_cnt is not cleared by a successful unlock or by DECOY exit; it is cleared only by rst.
- Data path, one register stage, selected by the current state:
  - FUNC: dout<=din.
  - OBF/DECOY: dout<=din ^ lfsr[DATA_W-1:0] (see Configuration).
  - BRICK: dout<=0.
- dout_vld<=din_vld in all states except BRICK, where dout_vld<=0.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle in OBF and DECOY; frozen in FUNC and BRICK.
- unlocked and bricked are decoded directly from the state register, with no extra register stage.

## Timing
- Key word sampled at edge N with a full match: unlocked=1 from cycle N+1.
- din sampled at edge M: dout/dout_vld visible from cycle M+1. The scrambling mode is chosen by the state held before edge M.
- Gaps between key words are allowed (idx held while key_vld=0).
- Wrong word at edge N: DECOY during cycles N+1..N+DECOY_CYC; OBF again at cycle N+DECOY_CYC+1.
- rst asserted mid-sequence or in DECOY/FUNC/BRICK: all reset values restored at the next edge; rst has priority over all inputs.

## Configuration
- DECOY_SCRAMBLE_EN defined: OBF/DECOY output = din ^ lfsr slice, as above.
- DECOY_SCRAMBLE_EN undefined:
  - OBF/DECOY output = 0, with dout_vld still following din_vld.
  - The LFSR and LFSR_SEED logic are removed.

## Structure
- Package keyed_seq_lock_pkg:
  - state enum (OBF, DECOY, FUNC, BRICK)
  - LFSR width and tap constants
  - default LFSR seed
- Sub-module lock_lfsr16:
  - ports: clk, rst, en, seed, state[15:0]
  - instantiated only under DECOY_SCRAMBLE_EN
- Counter widths: idx $clog2(KEY_LEN+1), fail_cnt $clog2(FAIL_LIMIT+1), decoy_cnt $clog2(DECOY_CYC+1).

## Test plan
- Unlock: default params; A1,B2,C3,D4 on consecutive cycles. Expect unlocked=1 the cycle after D4 is sampled. Then din=8'h5A, din_vld=1 -> dout=8'h5A, dout_vld=1 one cycle later.
- Gapped keys: A1, idle 3 cycles, B2, C3, idle, D4 -> unlocked=1.
- Wrong word: A1 then FF -> 4 cycles of DECOY with key words ignored, then OBF with idx=0. The full sequence A1..D4 then unlocks.
- Brick: three wrong words (each DECOY allowed to expire) -> bricked=1, dout_vld=0 even with din_vld=1. A following correct sequence leaves unlocked=0. rst clears bricked.
- Reset mid-sequence: A1, B2, rst, then C3 -> DECOY, not progress.
- Scramble: macro defined, din=8'h00 in OBF -> dout equals LFSR low byte (first value 8'hE1 from seed ACE1). Macro undefined -> dout=8'h00 with dout_vld=1.
